vmu_load_issue: RTL and testbench
=================================

# vmu_load_issue

Issue side of the vector memory unit's load path. Accepts strided load commands, breaks each into per-element D$ read requests, and stamps every request with a sequential reorder-queue tag. Throttles issue with a credit counter, so the tagged reorder queue that receives D$ responses can never hold more than its entry count. Credits are returned when writeback dequeues an entry from that queue.

## Interface
Parameters:
- `ADDR_SIZE`, 32, byte address width
- `VLEN_SIZE`, 11, element-count width
- `ROQ_TAG_ENTRIES`, 8, reorder-queue depth; must equal `2**ROQ_TAG_SIZE`
- `ROQ_TAG_SIZE`, 3, tag width

Ports:
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `cmd_val`  in  1  load command valid
- `cmd_rdy`  out  1  command accepted when `cmd_val & cmd_rdy`
- `cmd_base`  in  ADDR_SIZE  address of element 0
- `cmd_stride`  in  ADDR_SIZE  byte stride between elements; two's-complement wrap
- `cmd_vlen`  in  VLEN_SIZE  element count; 0 is legal
- `dmem_req_val`  out  1  D$ read request valid
- `dmem_req_rdy`  in  1  D$ accepts request
- `dmem_req_addr`  out  ADDR_SIZE  request address
- `dmem_req_tag`  out  ROQ_TAG_SIZE  reorder-queue slot for the response
- `roq_deq_fire`  in  1  writeback dequeued one queue entry this cycle (`val & rdy`)
- `busy`  out  1  command in progress or responses outstanding

## Operation
- State machine, two states:
  - IDLE
  - ISSUE
- IDLE:
  - `cmd_rdy=1`.
  - On accept with `cmd_vlen!=0`: latch `addr=cmd_base`, `stride=cmd_stride`, `remaining=cmd_vlen`, then go to ISSUE.
  - On accept with `cmd_vlen==0`: stay in IDLE; nothing is issued.
- ISSUE:
  - `cmd_rdy=0`.
  - `dmem_req_val = (credits_used < ROQ_TAG_ENTRIES)`.
  - `dmem_req_addr=addr`, `dmem_req_tag=tag_ptr`.
- Issue fire (`dmem_req_val & dmem_req_rdy`):
  - `addr += stride`, wrapping mod `2**ADDR_SIZE`.
  - `tag_ptr += 1`, wrapping mod `ROQ_TAG_ENTRIES`.
  - `remaining -= 1`.
  - `credits_used += 1`.
  - If `remaining` was 1, return to IDLE.
- `roq_deq_fire`:
  - Decrements `credits_used`.
  - If it coincides with an issue fire, `credits_used` is unchanged.
  - If it arrives while `credits_used==0`, it is ignored (saturate at 0); this is a protocol error flagged by assertion.
- `credits_used` is `ROQ_TAG_SIZE+1` bits wide, range 0..`ROQ_TAG_ENTRIES`.
- `tag_ptr` is never reset between commands. Tags continue across commands so the in-order queue read pointer stays aligned with it.
- `busy = (state==ISSUE) | (credits_used!=0)`.

## Timing
- Reset values:
  - state IDLE
  - `cmd_rdy=1`, `dmem_req_val=0`, `busy=0`
  - `dmem_req_addr=0`, `dmem_req_tag=0`
  - `credits_used=0`, `tag_ptr=0`, `remaining=0`
- Reset mid-command abandons all remaining elements and outstanding credits. The reorder queue shares the same reset.
- Command accepted in cycle N: first `dmem_req_val` can assert in cycle N+1.
- Peak throughput is one request per cycle while credits are available.
- `dmem_req_val`, `dmem_req_addr` and `dmem_req_tag` come from registers plus the credit compare only. `dmem_req_val` never depends on `dmem_req_rdy`.
- Once `dmem_req_val` is asserted, addr and tag hold stable until fire. Credits cannot decrease except through fire, so val cannot drop before fire.
- Credit return is registered. At `credits_used==ROQ_TAG_ENTRIES`, a `roq_deq_fire` in cycle N lets `dmem_req_val` assert in cycle N+1, not N.
- The last element fires in cycle N: IDLE and `cmd_rdy=1` in cycle N+1. `busy` stays high until the final credit returns.

## Structure
- Shared package or header entries:
  - `ROQ_TAG_ENTRIES` and `ROQ_TAG_SIZE` defaults, shared with the reorder queue
  - FSM state encoding
  - `ADDR_SIZE` / `VLEN_SIZE` defaults
- One natural sub-module: `vmu_roq_credit`, holding the credit counter and tag pointer. Its ports are issue-fire and deq-fire in; `credits_used`, `tag_ptr` and `has_credit` out.
- Address/count sequencing and the FSM stay in the top module.

## Test plan
- **Basic stride.** Command base=0x1000, stride=8, vlen=4, `dmem_req_rdy=1`, deq asserted every cycle after issue.
  - Addrs 0x1000/0x1008/0x1010/0x1018 with tags 0,1,2,3 on consecutive cycles.
  - `cmd_rdy` high the cycle after tag 3 fires.
  - `busy` low once all 4 deqs are seen.
- **Credit stall.** Command vlen=12, no deq.
  - Exactly 8 requests (tags 0..7), then `dmem_req_val=0`.
  - One `roq_deq_fire` in cycle N leads to request 9 with tag 0 in cycle N+1.
- **Backpressure.** `dmem_req_rdy` toggled 0/1 on a vlen=3, stride=−4 (0xFFFFFFFC) command from base 0x8.
  - Addr and tag held while rdy=0.
  - Addrs 0x8, 0x4, 0x0.
- **Wrap and simultaneous events.**
  - Two back-to-back commands (vlen 6, then vlen 5): tags run 0..5 then 6,7,0,1,2.
  - Issue fire and deq fire in the same cycle leave `credits_used` unchanged.
- **Edge commands.**
  - vlen=0 command: no request is issued, `cmd_rdy` stays 1.
  - `reset` asserted mid-issue with 5 credits used: next cycle shows IDLE, `busy=0`, tag 0 on the next command.

Source files
------------

// File: rtl/vmu_load_issue_pkg.sv
// Shared definitions for the vector-memory-unit load issue path.
// The reorder-queue sizing lives here so the issue side and the tagged
// reorder queue always agree on how many tags exist.
package vmu_load_issue_pkg;

   // Byte-address and element-count widths.
   localparam int ADDR_SIZE_DEF       = 32;
   localparam int VLEN_SIZE_DEF       = 11;

   // Reorder-queue depth and tag width. The depth must be a power of two
   // equal to 2**ROQ_TAG_SIZE so that tags wrap naturally in their width.
   localparam int ROQ_TAG_ENTRIES_DEF = 8;
   localparam int ROQ_TAG_SIZE_DEF    = 3;

   // Issue FSM encoding. Kept as plain constants so older code that
   // compares raw state bits keeps working.
   localparam int         STATE_W  = 1;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   // True when a credit count still leaves room in the reorder queue.
   function automatic logic credit_available(input int used, input int entries);
      return used < entries;
   endfunction

endpackage : vmu_load_issue_pkg

// File: rtl/vmu_load_issue_if.sv
// Command and D$ request bundle for the load issue unit.
//
// Handshake rule for every channel in this bundle: a transfer happens in
// the cycle where both valid and ready are high at the clock edge. Once the
// source raises valid it holds valid and its payload stable until that
// transfer; valid never depends on ready. roq_deq_fire is a one-cycle
// event that already represents a completed dequeue handshake.
interface vmu_load_issue_if
   import vmu_load_issue_pkg::*;
#(
   parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
   parameter int VLEN_SIZE    = VLEN_SIZE_DEF,
   parameter int ROQ_TAG_SIZE = ROQ_TAG_SIZE_DEF
);
   // Command channel
   logic                    cmd_val;
   logic                    cmd_rdy;
   logic [ADDR_SIZE-1:0]    cmd_base;
   logic [ADDR_SIZE-1:0]    cmd_stride;
   logic [VLEN_SIZE-1:0]    cmd_vlen;

   // D$ read request channel
   logic                    dmem_req_val;
   logic                    dmem_req_rdy;
   logic [ADDR_SIZE-1:0]    dmem_req_addr;
   logic [ROQ_TAG_SIZE-1:0] dmem_req_tag;

   // Writeback dequeue event from the reorder queue
   logic                    roq_deq_fire;

   // The load issue unit's view.
   modport slave (
      input  cmd_val, cmd_base, cmd_stride, cmd_vlen,
      output cmd_rdy,
      output dmem_req_val, dmem_req_addr, dmem_req_tag,
      input  dmem_req_rdy,
      input  roq_deq_fire
   );

   // The surrounding pipeline's view (command source, D$, writeback).
   modport master (
      output cmd_val, cmd_base, cmd_stride, cmd_vlen,
      input  cmd_rdy,
      input  dmem_req_val, dmem_req_addr, dmem_req_tag,
      output dmem_req_rdy,
      output roq_deq_fire
   );

endinterface : vmu_load_issue_if

// File: rtl/vmu_roq_credit.sv
// Credit counter and tag pointer for the tagged reorder queue.
// credits_used counts requests issued whose responses have not yet been
// dequeued by writeback; it never exceeds the queue depth, so the queue
// can never overflow. The tag pointer mirrors the queue's write order and
// is only cleared by reset.
module vmu_roq_credit
   import vmu_load_issue_pkg::*;
#(
   parameter int ROQ_TAG_ENTRIES = ROQ_TAG_ENTRIES_DEF,
   parameter int ROQ_TAG_SIZE    = ROQ_TAG_SIZE_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    issue_fire,
   input  logic                    deq_fire,
   output logic [ROQ_TAG_SIZE:0]   credits_used,
   output logic [ROQ_TAG_SIZE-1:0] tag_ptr,
   output logic                    has_credit
);

   localparam int                    CRED_W   = ROQ_TAG_SIZE + 1;
   localparam logic [CRED_W-1:0]       CRED_MAX = CRED_W'(ROQ_TAG_ENTRIES);
   localparam logic [CRED_W-1:0]       CRED_ONE = CRED_W'(1);
   localparam logic [ROQ_TAG_SIZE-1:0] TAG_ONE  = ROQ_TAG_SIZE'(1);

   // Room remains while fewer than ROQ_TAG_ENTRIES responses are owed.
   // Derived from the register only, so a returned credit takes effect
   // the cycle after the dequeue.
   assign has_credit = (credits_used < CRED_MAX);

   // Count outstanding responses; a coincident issue and dequeue cancel,
   // and a stray dequeue with nothing outstanding saturates at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_used <= '0;
      end else begin
         case ({issue_fire, deq_fire})
            2'b10:   credits_used <= credits_used + CRED_ONE;
            2'b01:   if (credits_used != '0) credits_used <= credits_used - CRED_ONE;
            default: credits_used <= credits_used;
         endcase
      end
   end

   // Advance the tag on every issued request; wraps in its own width.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_ptr <= '0;
      end else if (issue_fire) begin
         tag_ptr <= tag_ptr + TAG_ONE;
      end
   end

   // Writeback must never dequeue an entry that was never issued.
   a_deq_with_credit : assert property (@(posedge clk) disable iff (reset)
      !(deq_fire && (credits_used == '0)));

   // The issue side must never fire without a free queue slot.
   a_issue_with_credit : assert property (@(posedge clk) disable iff (reset)
      !(issue_fire && !has_credit));

   // The counter stays within 0..ROQ_TAG_ENTRIES.
   a_credit_range : assert property (@(posedge clk) disable iff (reset)
      credits_used <= CRED_MAX);

endmodule : vmu_roq_credit

// File: rtl/vmu_load_issue.sv
// Load issue unit of the vector memory unit. Takes strided load commands,
// walks the element addresses one request per cycle, stamps each request
// with the next reorder-queue tag and stalls whenever the reorder queue
// could be full.
module vmu_load_issue
   import vmu_load_issue_pkg::*;
#(
   parameter int ADDR_SIZE       = ADDR_SIZE_DEF,
   parameter int VLEN_SIZE       = VLEN_SIZE_DEF,
   parameter int ROQ_TAG_ENTRIES = ROQ_TAG_ENTRIES_DEF,
   parameter int ROQ_TAG_SIZE    = ROQ_TAG_SIZE_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   vmu_load_issue_if.slave       bus,
   output logic                  busy,
   output logic [STATE_W-1:0]    dbg_state,
   output logic [ROQ_TAG_SIZE:0] dbg_credits_used
);

   localparam logic [VLEN_SIZE-1:0] VLEN_ONE = VLEN_SIZE'(1);

   logic [STATE_W-1:0]      state;
   logic [ADDR_SIZE-1:0]    addr;
   logic [ADDR_SIZE-1:0]    stride;
   logic [VLEN_SIZE-1:0]    remaining;

   logic                    cmd_fire;
   logic                    cmd_start;
   logic                    issue_fire;
   logic                    last_elem;
   logic [ROQ_TAG_SIZE:0]   credits_used;
   logic [ROQ_TAG_SIZE-1:0] tag_ptr;
   logic                    has_credit;

   // Handshake decode. A zero-length command is accepted and dropped.
   assign bus.cmd_rdy = (state == ST_IDLE);
   assign cmd_fire    = bus.cmd_val & bus.cmd_rdy;
   assign cmd_start   = cmd_fire & (bus.cmd_vlen != '0);

   // Request outputs come straight from registers and the credit compare,
   // never from dmem_req_rdy, so the D$ side sees a clean valid.
   assign bus.dmem_req_val  = (state == ST_ISSUE) & has_credit;
   assign bus.dmem_req_addr = addr;
   assign bus.dmem_req_tag  = tag_ptr;
   assign issue_fire        = bus.dmem_req_val & bus.dmem_req_rdy;
   assign last_elem         = (remaining == VLEN_ONE);

   // Busy until the command is fully issued and every response dequeued.
   assign busy             = (state == ST_ISSUE) | (credits_used != '0);
   assign dbg_state        = state;
   assign dbg_credits_used = credits_used;

   // Credit counter and tag pointer live in their own block so the same
   // accounting can be reviewed alongside the reorder queue.
   vmu_roq_credit #(
      .ROQ_TAG_ENTRIES (ROQ_TAG_ENTRIES),
      .ROQ_TAG_SIZE    (ROQ_TAG_SIZE)
   ) u_credit (
      .clk          (clk),
      .reset        (reset),
      .issue_fire   (issue_fire),
      .deq_fire     (bus.roq_deq_fire),
      .credits_used (credits_used),
      .tag_ptr      (tag_ptr),
      .has_credit   (has_credit)
   );

   // FSM: leave IDLE on a non-empty command, return after the last element fires.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
         if (cmd_start) state <= ST_ISSUE;
      end else begin
         if (issue_fire && last_elem) state <= ST_IDLE;
      end
   end

   // Address/count sequencing: latch on command start, step on each issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr      <= '0;
         stride    <= '0;
         remaining <= '0;
      end else if (cmd_start) begin
         addr      <= bus.cmd_base;
         stride    <= bus.cmd_stride;
         remaining <= bus.cmd_vlen;
      end else if (issue_fire) begin
         addr      <= addr + stride;
         remaining <= remaining - VLEN_ONE;
      end
   end

   // A stalled request keeps its valid, address and tag until it fires.
   a_req_stable : assert property (@(posedge clk) disable iff (reset)
      (bus.dmem_req_val && !bus.dmem_req_rdy) |=>
         (bus.dmem_req_val && $stable(bus.dmem_req_addr) && $stable(bus.dmem_req_tag)));

   // Requests only go out while elements remain.
   a_issue_has_work : assert property (@(posedge clk) disable iff (reset)
      issue_fire |-> (remaining != '0));

   // In ISSUE there is always at least one element left to send.
   a_issue_nonzero : assert property (@(posedge clk) disable iff (reset)
      (state == ST_ISSUE) |-> (remaining != '0));

   // Commands are never accepted while a previous one is still issuing.
   a_no_cmd_in_issue : assert property (@(posedge clk) disable iff (reset)
      (state == ST_ISSUE) |-> !bus.cmd_rdy);

endmodule : vmu_load_issue

// File: tb/tb_vmu_load_issue.sv
// Self-checking bench for vmu_load_issue. Commands push their expected
// request stream (address = base + i*stride, tag = running count mod
// depth) into a queue; a monitor on the falling edge compares every fired
// request and the per-cycle flow-control outputs against that model.
module tb_vmu_load_issue;
   import vmu_load_issue_pkg::*;

   localparam int AW = 32;
   localparam int VW = 11;
   localparam int TE = 8;
   localparam int TS = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          busy;
   logic [0:0]    dbg_state;
   logic [TS:0]   dbg_credits;

   vmu_load_issue_if #(.ADDR_SIZE(AW), .VLEN_SIZE(VW), .ROQ_TAG_SIZE(TS)) bus ();

   vmu_load_issue #(
      .ADDR_SIZE(AW), .VLEN_SIZE(VW), .ROQ_TAG_ENTRIES(TE), .ROQ_TAG_SIZE(TS)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .busy             (busy),
      .dbg_state        (dbg_state),
      .dbg_credits_used (dbg_credits)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [AW+TS-1:0] exp_q[$];
   int               n_cmp = 0;
   int               n_err = 0;
   int               model_out = 0;
   int               tag_ctr = 0;
   int               rdy_mode = 0;
   int               deq_mode = 0;
   bit               deq_once = 1'b0;
   bit               mon_en = 1'b0;
   bit               prev_stall = 1'b0;
   logic [AW-1:0]    prev_addr;
   logic [TS-1:0]    prev_tag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && mon_en) begin
         logic          fire;
         logic          deq;
         logic [AW-1:0] e_addr;
         logic [TS-1:0] e_tag;
         fire = bus.dmem_req_val & bus.dmem_req_rdy;
         deq  = bus.roq_deq_fire;
         check("cmd_rdy", 32'(bus.cmd_rdy), 32'(exp_q.size() == 0));
         check("req_val", 32'(bus.dmem_req_val), 32'((exp_q.size() != 0) && (model_out < TE)));
         check("busy", 32'(busy), 32'((exp_q.size() != 0) || (model_out != 0)));
         check("credits_used", 32'(dbg_credits), 32'(model_out));
         if (prev_stall) begin
            check("hold_val", 32'(bus.dmem_req_val), 32'd1);
            check("hold_addr", bus.dmem_req_addr, prev_addr);
            check("hold_tag", 32'(bus.dmem_req_tag), 32'(prev_tag));
         end
         if (fire) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_req: got addr 0x%0h tag %0d expected none at %0t",
                        bus.dmem_req_addr, bus.dmem_req_tag, $time);
            end else begin
               {e_addr, e_tag} = exp_q.pop_front();
               check("req_addr", bus.dmem_req_addr, e_addr);
               check("req_tag", 32'(bus.dmem_req_tag), 32'(e_tag));
            end
         end
         prev_stall = bus.dmem_req_val & ~bus.dmem_req_rdy;
         prev_addr  = bus.dmem_req_addr;
         prev_tag   = bus.dmem_req_tag;
         if (fire && !deq) model_out++;
         else if (!fire && deq && model_out > 0) model_out--;
      end
   end

   // ---------------- background D$ / writeback driver ----------------
   initial begin
      bus.dmem_req_rdy = 1'b1;
      bus.roq_deq_fire = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.dmem_req_rdy = 1'b1;
            1:       bus.dmem_req_rdy = ~bus.dmem_req_rdy;
            default: bus.dmem_req_rdy = 1'($urandom_range(0, 1));
         endcase
         if (reset || model_out == 0) begin
            bus.roq_deq_fire = 1'b0;
         end else if (deq_once) begin
            bus.roq_deq_fire = 1'b1;
            deq_once = 1'b0;
         end else if (deq_mode == 1) begin
            bus.roq_deq_fire = 1'b1;
         end else if (deq_mode == 2) begin
            bus.roq_deq_fire = 1'($urandom_range(0, 1));
         end else begin
            bus.roq_deq_fire = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int vlen);
      int guard = 0;
      while (!bus.cmd_rdy && guard < 2000) begin
         tick();
         guard++;
      end
      if (!bus.cmd_rdy) begin
         n_cmp++;
         n_err++;
         $display("FAIL cmd_wait: got cmd_rdy 0 expected 1 within 2000 cycles");
      end
      bus.cmd_val    = 1'b1;
      bus.cmd_base   = base;
      bus.cmd_stride = stride;
      bus.cmd_vlen   = VW'(vlen);
      @(posedge clk);
      for (int i = 0; i < vlen; i++) begin
         logic [AW-1:0] a;
         logic [TS-1:0] t;
         a = base + stride * AW'(i);
         t = TS'(tag_ctr % TE);
         exp_q.push_back({a, t});
         tag_ctr++;
      end
      #1;
      bus.cmd_val = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      n_cmp++;
      if (busy || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got busy %0d pending %0d expected idle within %0d cycles",
                  busy, exp_q.size(), budget);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      exp_q.delete();
      model_out  = 0;
      tag_ctr    = 0;
      prev_stall = 1'b0;
      #1;
      reset = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int g;
      bus.cmd_val    = 1'b0;
      bus.cmd_base   = '0;
      bus.cmd_stride = '0;
      bus.cmd_vlen   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset values
      check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
      check("rst_req_val", 32'(bus.dmem_req_val), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", bus.dmem_req_addr, 32'd0);
      check("rst_tag", 32'(bus.dmem_req_tag), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_credits", 32'(dbg_credits), 32'd0);
      mon_en = 1'b1;

      // Basic stride with deq every cycle
      rdy_mode = 0;
      deq_mode = 1;
      send_cmd(32'h1000, 32'd8, 4);
      wait_idle(100);

      // Credit stall: 12 elements, no deq, then a single returned credit
      do_reset();
      deq_mode = 0;
      send_cmd(32'h2000, 32'd4, 12);
      repeat (14) tick();
      check("stall_credits", 32'(dbg_credits), TE);
      check("stall_val", 32'(bus.dmem_req_val), 32'd0);
      deq_once = 1'b1;
      repeat (4) tick();
      deq_mode = 1;
      wait_idle(200);

      // Backpressure with negative stride
      rdy_mode = 1;
      send_cmd(32'h8, 32'hFFFF_FFFC, 3);
      wait_idle(100);

      // Back-to-back commands wrapping the tag, random deq for coincidences
      do_reset();
      rdy_mode = 0;
      deq_mode = 2;
      send_cmd(32'h4000, 32'h10, 6);
      send_cmd(32'h5000, 32'h20, 5);
      deq_mode = 1;
      wait_idle(200);

      // Zero-length command
      send_cmd(32'h100, 32'd4, 0);
      repeat (3) tick();
      check("vlen0_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
      check("vlen0_busy", 32'(busy), 32'd0);

      // Reset mid-issue with 5 credits used
      deq_mode = 0;
      rdy_mode = 0;
      send_cmd(32'h6000, 32'd4, 10);
      g = 0;
      while (model_out < 5 && g < 100) begin
         tick();
         g++;
      end
      check("pre_reset_credits", 32'(dbg_credits), 32'd5);
      do_reset();
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_rdy", 32'(bus.cmd_rdy), 32'd1);
      check("post_reset_state", 32'(dbg_state), 32'd0);
      check("post_reset_tag", 32'(bus.dmem_req_tag), 32'd0);
      deq_mode = 1;
      send_cmd(32'h7000, 32'd4, 2);
      wait_idle(100);

      // Randomized commands and flow control
      for (int k = 0; k < 25; k++) begin
         rdy_mode = $urandom_range(0, 2);
         deq_mode = $urandom_range(1, 2);
         send_cmd(32'($urandom), 32'($urandom), $urandom_range(0, 20));
         if ($urandom_range(0, 3) == 0) wait_idle(500);
      end
      deq_mode = 1;
      wait_idle(2000);

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_vmu_load_issue
